// File: rtl/writeback_arbiter_l1_pkg.sv
// Shared micro-architecture constants for the writeback stage and its producers.
package writeback_arbiter_l1_pkg;

  // Register file address width (32 architectural registers, x0 hardwired zero).
  localparam int unsigned c_addr_bits = 5;
  // Register file data width.
  localparam int unsigned c_data_bits = 32;
  // Program counter width.
  localparam int unsigned c_pc_bits   = 32;

endpackage : writeback_arbiter_l1_pkg

// File: rtl/x_w_intf.sv
// Execute-to-writeback handshake: producer (X) offers a result with val and
// holds it until the consumer (W) raises rdy in the same cycle.
//   val/pc/seq_num/waddr/wdata/wen : X -> W result payload
//   rdy                            : W -> X accept strobe
interface X__WIntf #(
  parameter int unsigned p_seq_num_bits = 5
);
  import writeback_arbiter_l1_pkg::*;

  logic                      val;
  logic                      rdy;
  logic [c_pc_bits-1:0]      pc;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [c_addr_bits-1:0]    waddr;
  logic [c_data_bits-1:0]    wdata;
  logic                      wen;

  modport X_intf (output val, pc, seq_num, waddr, wdata, wen, input rdy);
  modport W_intf (input val, pc, seq_num, waddr, wdata, wen, output rdy);

endinterface : X__WIntf

// File: rtl/writeback_arbiter_l1_round_robin_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Pointer moves past the winner when en is high, otherwise holds.
//   clk, rst : clock, synchronous active-low reset
//   req      : request vector
//   grant    : one-hot grant, all zero while rst is low
//   en       : a granted transfer took place this cycle
module round_robin_arb #(
  parameter int unsigned p_width = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_width-1:0] req,
  output logic [p_width-1:0] grant,
  input  logic               en
);

  localparam int unsigned c_idx_bits = (p_width > 1) ? $clog2(p_width) : 1;

  logic [c_idx_bits-1:0] ptr;
  logic [c_idx_bits-1:0] ptr_next;
  logic [c_idx_bits-1:0] gidx;
  logic [c_idx_bits-1:0] idx_b;
  int unsigned           idx;
  logic                  found;

  // Scan from ptr, wrapping, and stop at the first requester.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    idx_b = '0;
    for (int unsigned off = 0; off < p_width; off++) begin
      idx   = (32'(ptr) + off) % p_width;
      idx_b = c_idx_bits'(idx);
      if (rst && !found && req[idx_b]) begin
        grant[idx_b] = 1'b1;
        gidx         = idx_b;
        found        = 1'b1;
      end
    end
  end

  // Winner gets lowest priority next time.
  always_comb begin
    ptr_next = ptr;
    if (en) begin
      ptr_next = (gidx == c_idx_bits'(p_width - 1)) ? '0 : c_idx_bits'(gidx + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule : round_robin_arb

// File: rtl/writeback_arbiter_l1.sv
// Writeback stage: accepts one execute result per cycle (round-robin across
// pipes), registers it, and writes the register file / reports a commit in the
// next cycle. Never stalls.
//   clk, rst       : clock, synchronous active-low reset
//   Ex[]           : per-pipe result handshake (W side)
//   rf_waddr/wdata : register file write address/data
//   rf_wen         : register file write enable (suppressed for x0)
//   commit_val     : one instruction retired this cycle
//   commit_pc      : PC of the retired instruction
//   commit_seq_num : sequence number of the retired instruction
module writeback_arbiter_l1
  import writeback_arbiter_l1_pkg::*;
#(
  parameter int unsigned p_num_pipes    = 2,
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  X__WIntf.W_intf                   Ex [p_num_pipes],
  output logic [c_addr_bits-1:0]    rf_waddr,
  output logic [c_data_bits-1:0]    rf_wdata,
  output logic                      rf_wen,
  output logic                      commit_val,
  output logic [c_pc_bits-1:0]      commit_pc,
  output logic [p_seq_num_bits-1:0] commit_seq_num
);

  typedef struct packed {
    logic                      val;
    logic [c_pc_bits-1:0]      pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [c_addr_bits-1:0]    waddr;
    logic [c_data_bits-1:0]    wdata;
    logic                      wen;
  } W_entry;

  logic [p_num_pipes-1:0] req;
  logic [p_num_pipes-1:0] grant;
  logic                   transfer;
  W_entry                 cand [p_num_pipes];
  W_entry                 w_next;
  W_entry                 w_q;
  logic                   rf_wen_q;

  // Flatten the interface array into local request/payload vectors.
  for (genvar g = 0; g < p_num_pipes; g++) begin : g_pipe
    assign req[g]    = Ex[g].val;
    assign Ex[g].rdy = grant[g];
    assign cand[g]   = '{val:     1'b1,
                         pc:      Ex[g].pc,
                         seq_num: Ex[g].seq_num,
                         waddr:   Ex[g].waddr,
                         wdata:   Ex[g].wdata,
                         wen:     Ex[g].wen};
  end

  assign transfer = |grant;

  round_robin_arb #(
    .p_width (p_num_pipes)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .en    (transfer)
  );

  // Mux the granted payload; grant is one-hot so order does not matter.
  always_comb begin
    w_next = '0;
    for (int unsigned i = 0; i < p_num_pipes; i++) begin
      if (grant[i]) begin
        w_next = cand[i];
      end
    end
  end

  // W register plus the pre-qualified RF write enable (x0 writes dropped).
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_q      <= '0;
      rf_wen_q <= 1'b0;
    end else begin
      w_q      <= w_next;
      rf_wen_q <= w_next.val & w_next.wen & (w_next.waddr != '0);
    end
  end

  assign commit_val     = w_q.val;
  assign commit_pc      = w_q.pc;
  assign commit_seq_num = w_q.seq_num;
  assign rf_waddr       = w_q.waddr;
  assign rf_wdata       = w_q.wdata;
  assign rf_wen         = rf_wen_q;

`ifndef SYNTHESIS
  // Fixed-width trace: seq_num, plus waddr:wdata at level > 0.
  function automatic string line_trace(input int level);
    string s;
    if (commit_val) begin
      s = $sformatf("%2d", commit_seq_num);
      if (level > 0) s = {s, $sformatf(" %02d:%08h", rf_waddr, rf_wdata)};
    end else begin
      s = "  ";
      if (level > 0) s = {s, "            "};
    end
    return s;
  endfunction
`endif

endmodule : writeback_arbiter_l1

// File: tb/tb_writeback_arbiter_l1.sv
module tb_writeback_arbiter_l1;

  logic        clk;
  logic        rst;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic        commit_val;
  logic [31:0] commit_pc;
  logic [4:0]  commit_seq_num;

  int n_total;
  int n_bad;

  X__WIntf #(.p_seq_num_bits(5)) ex_if [2] ();

  writeback_arbiter_l1 #(
    .p_num_pipes    (2),
    .p_seq_num_bits (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Ex             (ex_if),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .rf_wen         (rf_wen),
    .commit_val     (commit_val),
    .commit_pc      (commit_pc),
    .commit_seq_num (commit_seq_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pc is derived from seq so it can be checked independently.
  task automatic drive(input int p, input logic v, input logic [4:0] seq,
                       input logic [4:0] wa, input logic [31:0] wd, input logic we);
    if (p == 0) begin
      ex_if[0].val = v; ex_if[0].seq_num = seq; ex_if[0].waddr = wa;
      ex_if[0].wdata = wd; ex_if[0].wen = we; ex_if[0].pc = 32'h1000 + 32'(seq) * 4;
    end else begin
      ex_if[1].val = v; ex_if[1].seq_num = seq; ex_if[1].waddr = wa;
      ex_if[1].wdata = wd; ex_if[1].wen = we; ex_if[1].pc = 32'h1000 + 32'(seq) * 4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 1'b1, 5'd9, 5'd3, 32'h0000_0011, 1'b1);
    drive(1, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++; if (ex_if[0].rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy0: got %b want 0", ex_if[0].rdy); end
      n_total++; if (ex_if[1].rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy1: got %b want 0", ex_if[1].rdy); end
      n_total++; if (commit_val !== 1'b0) begin n_bad++; $display("FAIL reset_commit: got %b want 0", commit_val); end
      n_total++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_rf_wen: got %b want 0", rf_wen); end
    end
    rst = 1'b1;
    #1;
    n_total++; if (ex_if[0].rdy !== 1'b1) begin n_bad++; $display("FAIL release_rdy0: got %b want 1", ex_if[0].rdy); end
    @(negedge clk);
    n_total++; if (commit_val !== 1'b1) begin n_bad++; $display("FAIL release_commit: got %b want 1", commit_val); end
    n_total++; if (commit_seq_num !== 5'd9) begin n_bad++; $display("FAIL release_seq: got %0d want 9", commit_seq_num); end
    n_total++; if (commit_pc !== 32'h1024) begin n_bad++; $display("FAIL release_pc: got %h want 00001024", commit_pc); end
    n_total++; if (rf_wen !== 1'b1) begin n_bad++; $display("FAIL release_rf_wen: got %b want 1", rf_wen); end
    n_total++; if (rf_waddr !== 5'd3) begin n_bad++; $display("FAIL release_waddr: got %0d want 3", rf_waddr); end
    drive(0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic test_single();
    drive(1, 1'b1, 5'd3, 5'd5, 32'hDEAD_BEEF, 1'b1);
    #1;
    n_total++; if (ex_if[1].rdy !== 1'b1) begin n_bad++; $display("FAIL single_rdy1: got %b want 1", ex_if[1].rdy); end
    n_total++; if (ex_if[0].rdy !== 1'b0) begin n_bad++; $display("FAIL single_rdy0: got %b want 0", ex_if[0].rdy); end
    @(negedge clk);
    n_total++; if (rf_wen !== 1'b1) begin n_bad++; $display("FAIL single_rf_wen: got %b want 1", rf_wen); end
    n_total++; if (rf_waddr !== 5'd5) begin n_bad++; $display("FAIL single_waddr: got %0d want 5", rf_waddr); end
    n_total++; if (rf_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_wdata: got %h want deadbeef", rf_wdata); end
    n_total++; if (commit_seq_num !== 5'd3) begin n_bad++; $display("FAIL single_seq: got %0d want 3", commit_seq_num); end
    n_total++; if (commit_pc !== 32'h100C) begin n_bad++; $display("FAIL single_pc: got %h want 0000100c", commit_pc); end
    drive(1, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    n_total++; if (commit_val !== 1'b0) begin n_bad++; $display("FAIL single_idle_commit: got %b want 0", commit_val); end
    n_total++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL single_idle_wen: got %b want 0", rf_wen); end
  endtask

  task automatic test_x0();
    drive(0, 1'b1, 5'd4, 5'd0, 32'h0000_1234, 1'b1);
    #1;
    n_total++; if (ex_if[0].rdy !== 1'b1) begin n_bad++; $display("FAIL x0_rdy0: got %b want 1", ex_if[0].rdy); end
    @(negedge clk);
    n_total++; if (commit_val !== 1'b1) begin n_bad++; $display("FAIL x0_commit: got %b want 1", commit_val); end
    n_total++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL x0_rf_wen: got %b want 0", rf_wen); end
    n_total++; if (commit_seq_num !== 5'd4) begin n_bad++; $display("FAIL x0_seq: got %0d want 4", commit_seq_num); end
    drive(0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    drive(1, 1'b1, 5'd5, 5'd7, 32'h5555_5555, 1'b0);
    #1;
    n_total++; if (ex_if[1].rdy !== 1'b1) begin n_bad++; $display("FAIL nowen_rdy1: got %b want 1", ex_if[1].rdy); end
    @(negedge clk);
    n_total++; if (commit_val !== 1'b1) begin n_bad++; $display("FAIL nowen_commit: got %b want 1", commit_val); end
    n_total++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL nowen_rf_wen: got %b want 0", rf_wen); end
    n_total++; if (rf_waddr !== 5'd7) begin n_bad++; $display("FAIL nowen_waddr: got %0d want 7", rf_waddr); end
    n_total++; if (commit_seq_num !== 5'd5) begin n_bad++; $display("FAIL nowen_seq: got %0d want 5", commit_seq_num); end
    drive(1, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
  endtask

  // Pipe 0 holds seq 0,1; pipe 1 holds seq 2,3; waddr = 10+seq, wdata = A0000000+seq.
  task automatic test_contention();
    int   exp_g [4] = '{0, 1, 0, 1};
    int   exp_c [4] = '{0, 2, 1, 3};
    int   h0 = 0;
    int   h1 = 0;
    logic g0;
    logic g1;
    for (int k = 0; k < 4; k++) begin
      drive(0, h0 < 2, 5'(h0),     5'(10 + h0), 32'hA000_0000 + 32'(h0),     1'b1);
      drive(1, h1 < 2, 5'(2 + h1), 5'(12 + h1), 32'hA000_0002 + 32'(h1), 1'b1);
      #1;
      g0 = ex_if[0].rdy;
      g1 = ex_if[1].rdy;
      n_total++; if (g0 !== (exp_g[k] == 0)) begin n_bad++; $display("FAIL cont_rdy0[%0d]: got %b want %b", k, g0, exp_g[k] == 0); end
      n_total++; if (g1 !== (exp_g[k] == 1)) begin n_bad++; $display("FAIL cont_rdy1[%0d]: got %b want %b", k, g1, exp_g[k] == 1); end
      @(negedge clk);
      n_total++; if (commit_val !== 1'b1) begin n_bad++; $display("FAIL cont_commit[%0d]: got %b want 1", k, commit_val); end
      n_total++; if (commit_seq_num !== 5'(exp_c[k])) begin n_bad++; $display("FAIL cont_seq[%0d]: got %0d want %0d", k, commit_seq_num, exp_c[k]); end
      n_total++; if (rf_wdata !== 32'hA000_0000 + 32'(exp_c[k])) begin n_bad++; $display("FAIL cont_wdata[%0d]: got %h want %h", k, rf_wdata, 32'hA000_0000 + 32'(exp_c[k])); end
      n_total++; if (rf_waddr !== 5'(10 + exp_c[k])) begin n_bad++; $display("FAIL cont_waddr[%0d]: got %0d want %0d", k, rf_waddr, 10 + exp_c[k]); end
      if (g0 === 1'b1) h0++;
      if (g1 === 1'b1) h1++;
    end
    drive(0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    drive(1, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    n_total++; if (commit_val !== 1'b0) begin n_bad++; $display("FAIL cont_drain: got %b want 0", commit_val); end
  endtask

  task automatic test_ptr_hold();
    drive(0, 1'b1, 5'd7, 5'd1, 32'h7777_0000, 1'b1);
    #1;
    n_total++; if (ex_if[0].rdy !== 1'b1) begin n_bad++; $display("FAIL hold_rdy0: got %b want 1", ex_if[0].rdy); end
    @(negedge clk);
    n_total++; if (commit_seq_num !== 5'd7) begin n_bad++; $display("FAIL hold_seq7: got %0d want 7", commit_seq_num); end
    drive(0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++; if (commit_val !== 1'b0) begin n_bad++; $display("FAIL hold_idle[%0d]: got %b want 0", i, commit_val); end
    end
    drive(0, 1'b1, 5'd8, 5'd2, 32'h8888_0000, 1'b1);
    drive(1, 1'b1, 5'd9, 5'd3, 32'h9999_0000, 1'b1);
    #1;
    n_total++; if (ex_if[1].rdy !== 1'b1) begin n_bad++; $display("FAIL hold_first_rdy1: got %b want 1", ex_if[1].rdy); end
    n_total++; if (ex_if[0].rdy !== 1'b0) begin n_bad++; $display("FAIL hold_first_rdy0: got %b want 0", ex_if[0].rdy); end
    @(negedge clk);
    n_total++; if (commit_seq_num !== 5'd9) begin n_bad++; $display("FAIL hold_seq9: got %0d want 9", commit_seq_num); end
    drive(1, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    #1;
    n_total++; if (ex_if[0].rdy !== 1'b1) begin n_bad++; $display("FAIL hold_second_rdy0: got %b want 1", ex_if[0].rdy); end
    @(negedge clk);
    n_total++; if (commit_val !== 1'b1) begin n_bad++; $display("FAIL hold_commit8: got %b want 1", commit_val); end
    n_total++; if (commit_seq_num !== 5'd8) begin n_bad++; $display("FAIL hold_seq8: got %0d want 8", commit_seq_num); end
    drive(0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
  endtask

  // Pointer is at pipe 1 on entry; reset must drop the offer and send it back to 0.
  task automatic test_mid_reset();
    drive(1, 1'b1, 5'd10, 5'd4, 32'h0A0A_0A0A, 1'b1);
    #1;
    n_total++; if (ex_if[1].rdy !== 1'b1) begin n_bad++; $display("FAIL mid_pre_rdy1: got %b want 1", ex_if[1].rdy); end
    rst = 1'b0;
    #1;
    n_total++; if (ex_if[1].rdy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rdy1: got %b want 0", ex_if[1].rdy); end
    @(negedge clk);
    n_total++; if (commit_val !== 1'b0) begin n_bad++; $display("FAIL mid_commit: got %b want 0", commit_val); end
    n_total++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL mid_rf_wen: got %b want 0", rf_wen); end
    rst = 1'b1;
    drive(0, 1'b1, 5'd11, 5'd6, 32'h0B0B_0B0B, 1'b1);
    #1;
    n_total++; if (ex_if[0].rdy !== 1'b1) begin n_bad++; $display("FAIL mid_ptr0_rdy0: got %b want 1", ex_if[0].rdy); end
    n_total++; if (ex_if[1].rdy !== 1'b0) begin n_bad++; $display("FAIL mid_ptr0_rdy1: got %b want 0", ex_if[1].rdy); end
    @(negedge clk);
    n_total++; if (commit_seq_num !== 5'd11) begin n_bad++; $display("FAIL mid_seq11: got %0d want 11", commit_seq_num); end
    drive(0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
    #1;
    n_total++; if (ex_if[1].rdy !== 1'b1) begin n_bad++; $display("FAIL mid_retry_rdy1: got %b want 1", ex_if[1].rdy); end
    @(negedge clk);
    n_total++; if (commit_seq_num !== 5'd10) begin n_bad++; $display("FAIL mid_seq10: got %0d want 10", commit_seq_num); end
    n_total++; if (rf_wdata !== 32'h0A0A_0A0A) begin n_bad++; $display("FAIL mid_wdata: got %h want 0a0a0a0a", rf_wdata); end
    drive(1, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_single();
    test_x0();
    test_contention();
    test_ptr_hold();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_writeback_arbiter_l1
